cnn_frame_sequencer: RTL and testbench
======================================

// Module: cnn_frame_sequencer
// PURPOSE
//  Frame-level controller for the MNIST CNN pipeline (conv_5ks_1 -> mxp_relu -> conv_5ks_2 -> mxp_relu -> fc_layer -> comparator).
//  On start it clears the pipeline and streams one 28x28 frame from an external pixel RAM into conv_5ks_1, one pixel per cycle.
//  It then waits for the comparator's decision, latches the class and signals done.
//  Back-to-back frames are supported with a fresh pipeline clear before each frame.
// PARAMETERS
//  NUM_PIXELS   784   pixels per frame
//  ADDR_BIT     10    pixel RAM address width
//  PIX_BIT      8     pixel width
//  CLASS_BIT    4     decision width
//  CLR_CYCLES   2     cycles pipe_rst is held in CLR state (>=1)
//  TIMEOUT      4095  max WAIT cycles before abort (CNN_SEQ_TIMEOUT_EN only)
//  TIMEOUT_BIT  12    width of the timeout counter
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          asynchronous, active-low reset
//  start        in   1          frame request, level-sampled
//  busy         out  1          high in CLR/STREAM/WAIT
//  done         out  1          1-cycle pulse on entry to DONE
//  result       out  CLASS_BIT  latched decision; 4'hF on timeout
//  err_timeout  out  1          sticky timeout flag; cleared by next accepted start
//  pix_rd_en    out  1          pixel RAM read strobe
//  pix_addr     out  ADDR_BIT   pixel RAM address
//  pix_rdata    in   PIX_BIT    pixel RAM data; valid 1 cycle after pix_rd_en
//  pipe_rst     out  1          active-high reset to the CNN datapath
//  pipe_data    out  PIX_BIT    pixel stream to conv_5ks_1 in_data
//  dec_valid    in   1          comparator valid_out
//  dec_class    in   CLASS_BIT  comparator decision
// BEHAVIOUR
//  Reset (rst=0, async) values:
//   state=IDLE, busy=0, done=0, result=0, err_timeout=0, pix_rd_en=0, pix_addr=0, pipe_rst=1, pipe_data=0.
//   Reset mid-frame aborts the frame immediately; no done pulse is produced.
//  FSM: IDLE -> CLR -> STREAM -> WAIT -> DONE -> (IDLE | CLR).
//   IDLE
//    - pipe_rst=1.
//    - start=1 -> CLR; err_timeout cleared; clear counter loaded.
//   CLR
//    - pipe_rst=1, pipe_data=0, held for exactly CLR_CYCLES cycles, then -> STREAM.
//   STREAM
//    - pipe_rst=0.
//    - pix_rd_en=1 with pix_addr=0..NUM_PIXELS-1 on consecutive cycles, no gaps.
//    - pipe_data registers pix_rdata: address k issued in cycle t appears on pipe_data in cycle t+2.
//    - Exits to WAIT the cycle after pixel NUM_PIXELS-1 is driven (2 cycles after last address).
//    - pix_rd_en=0 after the last address; pix_addr holds NUM_PIXELS-1.
//   WAIT
//    - pipe_rst=0, pipe_data=0.
//    - dec_valid=1 -> result<=dec_class, -> DONE.
//    - dec_valid in any other state is ignored.
//   DONE
//    - Lasts exactly 1 cycle; done=1, busy=0, pipe_rst=1.
//    - start=1 in this cycle -> CLR (back-to-back frame); otherwise -> IDLE.
//  start during CLR/STREAM/WAIT is ignored; it is not queued.
//  busy rises the cycle after start is accepted.
//  Latency start->first pipe_data pixel = CLR_CYCLES+3 cycles.
//  Address counter saturates at NUM_PIXELS-1 and never wraps.
//  result holds its value until the next DONE.
// CONFIGURATION
//  CNN_SEQ_TIMEOUT_EN defined:
//   - WAIT counts cycles from 0.
//   - If the count reaches TIMEOUT with dec_valid=0: result<=4'hF, err_timeout<=1, -> DONE (done pulses).
//   - dec_valid and timeout in the same cycle: dec_valid wins.
//  CNN_SEQ_TIMEOUT_EN undefined:
//   - No counter; WAIT holds indefinitely; err_timeout is tied to 0.
// TESTING
//  1. RAM preloaded with pixel k = k[7:0]; start for 1 cycle.
//     -> pipe_rst high for 2 cycles, then pipe_data = 0,1,..,255,0,.. for 784 consecutive cycles.
//     -> pix_addr 0..783 with no gaps.
//  2. Feed dec_valid=1 with dec_class=3 during WAIT.
//     -> result=3 and done=1 for exactly 1 cycle, on the cycle after dec_valid; busy=0 in that cycle.
//  3. Hold start=1 continuously.
//     -> DONE goes directly to CLR; second frame pix_addr restarts at 0; pipe_rst high for 2 cycles between frames.
//  4. Pulse start and dec_valid=1 (dec_class=7) at pixel 400.
//     -> Both ignored: no restart, pix_addr continues 401..; result is unchanged at DONE entry.
//  5. Drive rst=0 at pixel 500.
//     -> All outputs take reset values asynchronously, pipe_rst=1.
//     -> After release, stays in IDLE until start; no done pulse.
//  6. With CNN_SEQ_TIMEOUT_EN and TIMEOUT=16, no dec_valid.
//     -> 16 cycles after WAIT entry: result=4'hF, err_timeout=1, done pulse.
//     -> err_timeout cleared by the next accepted start.

Source files
------------

// File: rtl/cnn_frame_sequencer_if.sv
// Pixel-RAM read port, CNN datapath feed and comparator decision bundle for the frame sequencer.
interface cnn_frame_sequencer_if #(
  parameter int unsigned ADDR_BIT  = 10,
  parameter int unsigned PIX_BIT   = 8,
  parameter int unsigned CLASS_BIT = 4
) ();
  logic                 pix_rd_en;
  logic [ADDR_BIT-1:0]  pix_addr;
  logic [PIX_BIT-1:0]   pix_rdata;
  logic                 pipe_rst;
  logic [PIX_BIT-1:0]   pipe_data;
  logic                 dec_valid;
  logic [CLASS_BIT-1:0] dec_class;

  modport master (
    output pix_rd_en, pix_addr, pipe_rst, pipe_data,
    input  pix_rdata, dec_valid, dec_class
  );

  modport slave (
    input  pix_rd_en, pix_addr, pipe_rst, pipe_data,
    output pix_rdata, dec_valid, dec_class
  );
endinterface

// File: rtl/cnn_frame_sequencer.sv
// Frame-level controller: clears the CNN pipeline, streams one frame from pixel RAM, latches the
// decision. Optional WAIT timeout is enabled by defining CNN_SEQ_TIMEOUT_EN.
module cnn_frame_sequencer #(
  parameter int unsigned NUM_PIXELS  = 784,
  parameter int unsigned ADDR_BIT    = 10,
  parameter int unsigned PIX_BIT     = 8,
  parameter int unsigned CLASS_BIT   = 4,
  parameter int unsigned CLR_CYCLES  = 2,
  parameter int unsigned TIMEOUT     = 4095,
  parameter int unsigned TIMEOUT_BIT = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [CLASS_BIT-1:0]  result,
  output logic                  err_timeout,
  cnn_frame_sequencer_if.master bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StClr    = 3'd1;
  localparam logic [2:0] StStream = 3'd2;
  localparam logic [2:0] StWait   = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  localparam int unsigned ClrW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [ClrW-1:0]     ClrInit  = ClrW'(CLR_CYCLES - 1);
  localparam logic [ADDR_BIT-1:0] LastAddr = ADDR_BIT'(NUM_PIXELS - 1);

  logic [2:0]           state_q, state_d;
  logic [ClrW-1:0]      clr_cnt_q, clr_cnt_d;
  logic [ADDR_BIT-1:0]  addr_q, addr_d;
  logic                 addr_done_q, addr_done_d;
  logic                 rd_dly_q;
  logic [PIX_BIT-1:0]   pipe_data_q, pipe_data_d;
  logic [CLASS_BIT-1:0] result_q, result_d;
  logic                 rd_en;
  logic                 start_acc;
  logic                 timeout_hit;

  assign rd_en = (state_q == StStream) && !addr_done_q;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    addr_d      = addr_q;
    addr_done_d = addr_done_q;
    result_d    = result_q;
    start_acc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StClr;
          start_acc = 1'b1;
        end
      end
      StClr: begin
        if (clr_cnt_q == '0) begin
          state_d = StStream;
        end else begin
          clr_cnt_d = clr_cnt_q - 1'b1;
        end
      end
      StStream: begin
        if (rd_en) begin
          if (addr_q == LastAddr) begin
            addr_done_d = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
        // Leave once the final pixel's RAM read has been forwarded onto pipe_data.
        if (addr_done_q && !rd_dly_q) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.dec_valid) begin
          result_d = bus.dec_class;
          state_d  = StDone;
        end else if (timeout_hit) begin
          result_d = '1;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (start) begin
          state_d   = StClr;
          start_acc = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (start_acc) begin
      clr_cnt_d   = ClrInit;
      addr_d      = '0;
      addr_done_d = 1'b0;
    end
  end

  assign pipe_data_d = ((state_q == StStream) && rd_dly_q) ? bus.pix_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      clr_cnt_q   <= '0;
      addr_q      <= '0;
      addr_done_q <= 1'b0;
      rd_dly_q    <= 1'b0;
      pipe_data_q <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      addr_q      <= addr_d;
      addr_done_q <= addr_done_d;
      rd_dly_q    <= rd_en;
      pipe_data_q <= pipe_data_d;
      result_q    <= result_d;
    end
  end

`ifdef CNN_SEQ_TIMEOUT_EN
  logic [TIMEOUT_BIT-1:0] wait_q;
  logic                   err_q;

  // Firing one count early makes DONE land exactly TIMEOUT cycles after WAIT entry.
  assign timeout_hit = (state_q == StWait) && !bus.dec_valid &&
                       (wait_q == TIMEOUT_BIT'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= (state_q == StWait) ? wait_q + 1'b1 : '0;
      if (start_acc) begin
        err_q <= 1'b0;
      end else if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT == 0) || (TIMEOUT_BIT == 0);
  assign timeout_hit        = 1'b0;
  assign err_timeout        = 1'b0;
`endif

  assign busy          = (state_q == StClr) || (state_q == StStream) || (state_q == StWait);
  assign done          = (state_q == StDone);
  assign result        = result_q;
  assign bus.pix_rd_en = rd_en;
  assign bus.pix_addr  = addr_q;
  assign bus.pipe_rst  = !((state_q == StStream) || (state_q == StWait));
  assign bus.pipe_data = pipe_data_q;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed bench for cnn_frame_sequencer: stream timing, decision latch, back-to-back frames,
// ignored mid-frame requests, asynchronous reset and (with CNN_SEQ_TIMEOUT_EN) the WAIT timeout.
module tb_cnn_frame_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  cnn_frame_sequencer_if #(.ADDR_BIT(10), .PIX_BIT(8), .CLASS_BIT(4)) bus ();

  cnn_frame_sequencer #(
    .NUM_PIXELS (784),
    .ADDR_BIT   (10),
    .PIX_BIT    (8),
    .CLASS_BIT  (4),
    .CLR_CYCLES (2),
    .TIMEOUT    (16),
    .TIMEOUT_BIT(12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .err_timeout(err_timeout),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel RAM preloaded with pixel k = k[7:0], one-cycle read latency.
  always @(posedge clk) begin
    if (bus.pix_rd_en) bus.pix_rdata <= bus.pix_addr[7:0];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge of the cycle in which start is accepted (cycle 0); returns in the
  // first WAIT cycle (cycle 789).
  task automatic stream_frame(input string tag, input bit inject, input bit hold,
                              input logic [3:0] prev_result);
    int   bad;
    int   e_addr;
    int   e_data;
    logic e_rd;
    logic e_prst;
    bad = 0;
    for (int c = 1; c <= 789; c++) begin
      @(negedge clk);
      if (c == 1) start = hold;
      e_rd   = (c >= 3 && c <= 786);
      e_addr = (c < 3) ? 0 : ((c <= 786) ? c - 3 : 783);
      e_prst = (c < 3);
      e_data = (c >= 5 && c <= 788) ? (c - 5) % 256 : 0;
      if (bus.pix_rd_en !== e_rd || bus.pix_addr !== 10'(e_addr) || bus.pipe_rst !== e_prst ||
          bus.pipe_data !== 8'(e_data) || busy !== 1'b1 || done !== 1'b0) begin
        if (bad == 0) $display("  %s: first divergence at stream cycle %0d", tag, c);
        bad++;
      end
      if (inject && c == 403) begin
        start     = 1'b1;
        bus.dec_valid = 1'b1;
        bus.dec_class = 4'd7;
      end
      if (inject && c == 404) begin
        start     = hold;
        bus.dec_valid = 1'b0;
      end
    end
    check_eq({tag, "_stream"}, bad, 0);
    check_eq({tag, "_wait_result"}, result, prev_result);
  endtask

  // Entered in WAIT; ends in the DONE cycle if hold, else in the following IDLE cycle.
  task automatic finish_frame(input string tag, input logic [3:0] cls, input bit hold);
    repeat (4) @(negedge clk);
    check_eq({tag, "_wait_busy"}, {busy, done}, 2'b10);
    bus.dec_valid = 1'b1;
    bus.dec_class = cls;
    @(negedge clk);
    bus.dec_valid = 1'b0;
    check_eq({tag, "_done"}, {done, busy, bus.pipe_rst}, 3'b101);
    check_eq({tag, "_result"}, result, cls);
    if (!hold) begin
      @(negedge clk);
      check_eq({tag, "_idle"}, {done, busy}, 2'b00);
    end
  endtask

  initial begin
    int bad;
    rst           = 1'b0;
    start         = 1'b0;
    bus.dec_valid = 1'b0;
    bus.dec_class = 4'd0;

    @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_result", result, 4'd0);
    check_eq("rst_err", err_timeout, 1'b0);
    check_eq("rst_rd_en", bus.pix_rd_en, 1'b0);
    check_eq("rst_addr", bus.pix_addr, 10'd0);
    check_eq("rst_pipe_rst", bus.pipe_rst, 1'b1);
    check_eq("rst_pipe_data", bus.pipe_data, 8'd0);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_hold", {busy, done, bus.pipe_rst}, 3'b001);

    // Single frame, decision 3.
    start = 1'b1;
    stream_frame("f1", 1'b0, 1'b0, 4'd0);
    finish_frame("f1", 4'd3, 1'b0);

    // start and dec_valid pulsed mid-stream must be ignored.
    start = 1'b1;
    stream_frame("f2", 1'b1, 1'b0, 4'd3);
    finish_frame("f2", 4'd9, 1'b0);

    // start held high: DONE goes straight into a fresh CLR.
    start = 1'b1;
    stream_frame("f3", 1'b0, 1'b1, 4'd9);
    finish_frame("f3", 4'd5, 1'b1);
    stream_frame("f4", 1'b0, 1'b1, 4'd5);
    start = 1'b0;
    finish_frame("f4", 4'd6, 1'b0);

    // Asynchronous reset in the middle of a frame.
    start = 1'b1;
    for (int c = 1; c <= 505; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    check_eq("mid_pipe_data", bus.pipe_data, 8'd244);
    check_eq("mid_addr", bus.pix_addr, 10'd502);
    #2 rst = 1'b0;
    #1;
    check_eq("async_outputs", {busy, done, bus.pix_rd_en, bus.pipe_rst},
             4'b0001);
    check_eq("async_addr", bus.pix_addr, 10'd0);
    check_eq("async_data", bus.pipe_data, 8'd0);
    check_eq("async_result", result, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check_eq("post_rst_idle", bad, 0);

    start = 1'b1;
    stream_frame("f5", 1'b0, 1'b0, 4'd0);
`ifdef CNN_SEQ_TIMEOUT_EN
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b1) bad++;
    end
    check_eq("to_wait", bad, 0);
    @(negedge clk);
    check_eq("to_done", {done, busy}, 2'b10);
    check_eq("to_result", result, 4'hF);
    check_eq("to_err", err_timeout, 1'b1);
    @(negedge clk);
    check_eq("to_err_sticky", err_timeout, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("to_err_clear", {err_timeout, busy}, 2'b01);
`else
    repeat (40) @(negedge clk);
    check_eq("no_timeout", {busy, done, err_timeout}, 3'b100);
    finish_frame("f5", 4'd2, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
